// File: rtl/asip_pkg.sv
// Shared widths and the writeback-stage state encoding for the ASIP datapath.
package asip_pkg;
    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int VEC_W  = LANES * DATA_W;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 4;
    localparam int BEAT_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mws_state_t;
endpackage

// File: rtl/vec_lane_packer.sv
// Beat counter plus lane select: extracts the store lane for the current beat
// and inserts returned read data into the matching lane of the load buffer.
module vec_lane_packer
    import asip_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              adv,
    input  logic              vf,
    input  logic [VEC_W-1:0]  sdata,
    input  logic [VEC_W-1:0]  rbuf,
    input  logic [DATA_W-1:0] rdata,
    output logic [BEAT_W-1:0] beat,
    output logic [DATA_W-1:0] wdata,
    output logic [VEC_W-1:0]  rbuf_next,
    output logic              last_beat
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
        end else if (start) begin
            beat <= '0;
        end else if (adv) begin
            beat <= beat + 1'b1;
        end
    end

    assign wdata = sdata[beat*DATA_W +: DATA_W];

    always_comb begin
        rbuf_next = rbuf;
        rbuf_next[beat*DATA_W +: DATA_W] = rdata;
    end

    // Scalar accesses never advance past beat 0, so every beat is the last.
    assign last_beat = vf ? (beat == BEAT_W'(LANES - 1)) : 1'b1;
endmodule

// File: rtl/mem_writeback_stage.sv
// Memory/writeback stage: ALU pass-through or scalar/vector memory access over a
// single-word req/ack port, then a one-cycle writeback pulse to the register files.
// Handshake: upstream result is taken when in_valid && in_ready; memory beat
// completes when mem_req && mem_ack, with request fields held stable until then.
module mem_writeback_stage
    import asip_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              VF_in,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              WBEn_in,
    input  logic [REG_W-1:0]  R_V_dest_in,
    input  logic [VEC_W-1:0]  ALURES_in,
    input  logic [VEC_W-1:0]  StoreData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              WBEn3,
    output logic              VF3,
    output logic [REG_W-1:0]  R_V_dest3,
    output logic [VEC_W-1:0]  ResRV,
    output mws_state_t        state_dbg
);
    mws_state_t        state;
    logic              vf_q, load_q, store_q, wben_q;
    logic [REG_W-1:0]  dest_q;
    logic [ADDR_W-1:0] base_q;
    logic [VEC_W-1:0]  sdata_q, rbuf_q, rbuf_next;
    logic [BEAT_W-1:0] beat;
    logic [DATA_W-1:0] lane_wdata;
    logic              last_beat, is_mem, start;

    assign is_mem    = MemRead | MemWrite;
    assign start     = (state == IDLE) & in_valid & is_mem;
    assign in_ready  = (state == IDLE);
    assign mem_req   = (state == ACCESS);
    assign mem_we    = mem_req & store_q;
    assign mem_addr  = mem_req ? base_q + ADDR_W'({beat, 2'b00}) : '0;
    assign mem_wdata = mem_we ? lane_wdata : '0;
    assign state_dbg = state;

    vec_lane_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .adv       (mem_req & mem_ack),
        .vf        (vf_q),
        .sdata     (sdata_q),
        .rbuf      (rbuf_q),
        .rdata     (mem_rdata),
        .beat      (beat),
        .wdata     (lane_wdata),
        .rbuf_next (rbuf_next),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            vf_q      <= 1'b0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            wben_q    <= 1'b0;
            dest_q    <= '0;
            base_q    <= '0;
            sdata_q   <= '0;
            rbuf_q    <= '0;
            wb_valid  <= 1'b0;
            WBEn3     <= 1'b0;
            VF3       <= 1'b0;
            R_V_dest3 <= '0;
            ResRV     <= '0;
        end else begin
            wb_valid <= 1'b0;
            WBEn3    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && is_mem) begin
                        vf_q    <= VF_in;
                        load_q  <= MemRead;
                        // A request flagged as both load and store behaves as a load.
                        store_q <= MemWrite & ~MemRead;
                        wben_q  <= WBEn_in;
                        dest_q  <= R_V_dest_in;
                        base_q  <= ALURES_in[ADDR_W-1:0];
                        sdata_q <= StoreData;
                        rbuf_q  <= '0;
                        state   <= ACCESS;
                    end else if (in_valid) begin
                        wb_valid  <= 1'b1;
                        WBEn3     <= WBEn_in;
                        VF3       <= VF_in;
                        R_V_dest3 <= R_V_dest_in;
                        ResRV     <= ALURES_in;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (load_q) rbuf_q <= rbuf_next;
                        if (last_beat) begin
                            state     <= DONE;
                            wb_valid  <= 1'b1;
                            WBEn3     <= wben_q & load_q;
                            VF3       <= vf_q;
                            R_V_dest3 <= dest_q;
                            ResRV     <= load_q ? rbuf_next : '0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed bench for mem_writeback_stage: pass-through, scalar/vector loads and
// stores, address wrap, mid-access reset and the load+store corner case.
module tb_mem_writeback_stage;
    import asip_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              VF_in, MemRead, MemWrite, WBEn_in;
    logic [REG_W-1:0]  R_V_dest_in;
    logic [VEC_W-1:0]  ALURES_in, StoreData;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              wb_valid, WBEn3, VF3;
    logic [REG_W-1:0]  R_V_dest3;
    logic [VEC_W-1:0]  ResRV;
    mws_state_t        state_dbg;

    int total = 0;
    int bad = 0;
    int ack_wait = 0;
    int wcnt = 0;
    logic [64:0] exp_q[$];

    mem_writeback_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .VF_in(VF_in), .MemRead(MemRead), .MemWrite(MemWrite), .WBEn_in(WBEn_in),
        .R_V_dest_in(R_V_dest_in), .ALURES_in(ALURES_in), .StoreData(StoreData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .WBEn3(WBEn3),
        .VF3(VF3), .R_V_dest3(R_V_dest3), .ResRV(ResRV), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h1234_5678);
    endfunction

    task automatic push_beat(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({we, a, d});
    endtask

    // Memory responder: acks after ack_wait idle cycles and scores each beat.
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst && mem_req) begin
            if (wcnt == ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_model(mem_addr);
                wcnt      = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {mem_we, mem_addr, mem_wdata}, '1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {mem_we, mem_addr, mem_wdata}, e);
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    // driver: present one instruction for a single cycle (called at a negedge)
    task automatic send(input logic vf, input logic rd, input logic wr, input logic wben,
                        input logic [REG_W-1:0] dest, input logic [VEC_W-1:0] alu,
                        input logic [VEC_W-1:0] sd);
        VF_in = vf; MemRead = rd; MemWrite = wr; WBEn_in = wben;
        R_V_dest_in = dest; ALURES_in = alu; StoreData = sd;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic wait_wb(input int max_cyc, input logic [ADDR_W-1:0] watch,
                           output logic [VEC_W-1:0] res, output logic [REG_W-1:0] dest,
                           output logic vf, output logic we, output int req_cyc,
                           output int hits, output int ready_hi);
        bit found = 0;
        res = '0; dest = '0; vf = 0; we = 0; req_cyc = 0; hits = 0; ready_hi = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (in_ready) ready_hi++;
            if (wb_valid) begin
                res = ResRV; dest = R_V_dest3; vf = VF3; we = WBEn3;
                found = 1;
                break;
            end
            if (mem_req) begin
                req_cyc++;
                if (mem_addr == watch) hits++;
            end
            @(negedge clk);
        end
        if (!found) check("wb_timeout", 0, 1);
    endtask

    initial begin
        logic [VEC_W-1:0] res;
        logic [REG_W-1:0] dest;
        logic vf, we;
        int req_cyc, hits, ready_hi, wb_seen;
        bit seen;

        rst = 1'b0; in_valid = 0; VF_in = 0; MemRead = 0; MemWrite = 0; WBEn_in = 0;
        R_V_dest_in = '0; ALURES_in = '0; StoreData = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_resrv", ResRV, 0);
        check("rst_wben_vf_dest", {WBEn3, VF3, R_V_dest3}, 0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b1;
        @(negedge clk);

        // 1: back-to-back pass-through
        VF_in = 1; WBEn_in = 1; R_V_dest_in = 4'd3;
        ALURES_in = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A; in_valid = 1;
        @(negedge clk);
        check("pt0_valid", wb_valid, 1);
        check("pt0_res", ResRV, 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A);
        check("pt0_ctl", {WBEn3, VF3, R_V_dest3}, {1'b1, 1'b1, 4'd3});
        VF_in = 0; WBEn_in = 1; R_V_dest_in = 4'd5; ALURES_in = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        @(negedge clk);
        check("pt1_valid", wb_valid, 1);
        check("pt1_res", ResRV, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        check("pt1_ctl", {WBEn3, VF3, R_V_dest3}, {1'b1, 1'b0, 4'd5});
        WBEn_in = 0; R_V_dest_in = 4'd7; ALURES_in = 128'h77;
        @(negedge clk);
        check("pt2_valid", wb_valid, 1);
        check("pt2_ctl", {WBEn3, VF3, R_V_dest3, ResRV[7:0]}, {1'b0, 1'b0, 4'd7, 8'h77});
        in_valid = 0;
        @(negedge clk);
        check("pt_idle_valid", {wb_valid, WBEn3}, 0);
        check("pt_idle_hold", {R_V_dest3, ResRV}, {4'd7, 128'h77});

        // 2: scalar load with two wait cycles per beat
        ack_wait = 2;
        push_beat(0, 32'h100, 32'h0);
        send(0, 1, 0, 1, 4'd2, 128'h100, '0);
        wait_wb(30, 32'h100, res, dest, vf, we, req_cyc, hits, ready_hi);
        check("sld_res", res, 128'hDEADBEEF);
        check("sld_ctl", {we, vf, dest}, {1'b1, 1'b0, 4'd2});
        check("sld_req_cycles", req_cyc, 3);
        check("sld_addr_held", hits, 3);
        check("sld_ready_low", ready_hi, 0);
        check("sld_beats_left", exp_q.size(), 0);
        @(negedge clk);
        check("sld_after", {in_ready, wb_valid, WBEn3}, {1'b1, 1'b0, 1'b0});

        // 3: vector store
        ack_wait = 0;
        push_beat(1, 32'h200, 32'd1);
        push_beat(1, 32'h204, 32'd2);
        push_beat(1, 32'h208, 32'd3);
        push_beat(1, 32'h20C, 32'd4);
        send(1, 0, 1, 1, 4'd9, 128'h200, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_wb(30, 32'h200, res, dest, vf, we, req_cyc, hits, ready_hi);
        check("vst_ctl", {we, vf, dest}, {1'b0, 1'b1, 4'd9});
        check("vst_req_cycles", req_cyc, 4);
        check("vst_beats_left", exp_q.size(), 0);
        @(negedge clk);

        // 4: vector load wrapping past the top of the address space
        ack_wait = 1;
        push_beat(0, 32'hFFFF_FFF8, 32'h0);
        push_beat(0, 32'hFFFF_FFFC, 32'h0);
        push_beat(0, 32'h0000_0000, 32'h0);
        push_beat(0, 32'h0000_0004, 32'h0);
        send(1, 1, 0, 1, 4'd6, 128'hFFFF_FFF8, 128'h5555);
        wait_wb(40, 32'h0, res, dest, vf, we, req_cyc, hits, ready_hi);
        check("vld_res", res, 128'h1234567C_12345678_EDCBA984_EDCBA980);
        check("vld_ctl", {we, vf, dest}, {1'b1, 1'b1, 4'd6});
        check("vld_req_cycles", req_cyc, 8);
        check("vld_beats_left", exp_q.size(), 0);
        @(negedge clk);

        // 5: reset during beat 2 of a vector load
        ack_wait = 1;
        push_beat(0, 32'h500, 32'h0);
        push_beat(0, 32'h504, 32'h0);
        push_beat(0, 32'h508, 32'h0);
        push_beat(0, 32'h50C, 32'h0);
        send(1, 1, 0, 1, 4'd1, 128'h500, '0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && mem_addr == 32'h508) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("rstmid_reached_beat2", seen, 1);
        rst = 1'b0;
        #1;
        check("rstmid_req_drop", mem_req, 0);
        check("rstmid_ready", {in_ready, wb_valid}, {1'b1, 1'b0});
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wb_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid) wb_seen++;
        end
        check("rstmid_no_wb", wb_seen, 0);
        check("rstmid_ready_after", in_ready, 1);
        ack_wait = 0;
        push_beat(0, 32'h40, 32'h0);
        send(0, 1, 0, 1, 4'd4, 128'h40, '0);
        wait_wb(20, 32'h40, res, dest, vf, we, req_cyc, hits, ready_hi);
        check("rstmid_new_res", res, 128'h12345638);
        check("rstmid_new_ctl", {we, vf, dest}, {1'b1, 1'b0, 4'd4});
        @(negedge clk);

        // 6: load and store both set acts as a single-beat load
        ack_wait = 1;
        push_beat(0, 32'h80, 32'h0);
        send(0, 1, 1, 1, 4'd11, 128'h80, {4{32'hFFFF_FFFF}});
        wait_wb(20, 32'h80, res, dest, vf, we, req_cyc, hits, ready_hi);
        check("both_res", res, 128'h123456F8);
        check("both_ctl", {we, vf, dest}, {1'b1, 1'b0, 4'd11});
        check("both_req_cycles", req_cyc, 2);
        check("both_beats_left", exp_q.size(), 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
